// File: rtl/pe_pkg.sv
// ---------------------------------------------------------------------------
// pe_pkg
//   Shared definitions for the priority-encoder index interface.
//   - DEF_WIDTH / DEF_IDX_BITS / DEF_CNT_W : default block parameters
//   - bin2oh(idx, width)   : one-hot decode of a binary index. It returns
//                            all zeros when idx >= width.
//   - sat_inc(val, cnt_w)  : increments val and saturates at 2**cnt_w-1
//
//   Both helpers work on fixed maximum widths (MAX_WIDTH, MAX_CNT_W).
//   Callers truncate the result to their own parameterised width.
// ---------------------------------------------------------------------------
package pe_pkg;

    localparam int unsigned DEF_WIDTH    = 8;
    localparam int unsigned DEF_IDX_BITS = $clog2(DEF_WIDTH);
    localparam int unsigned DEF_CNT_W    = 8;

    localparam int unsigned MAX_WIDTH = 64;
    localparam int unsigned MAX_CNT_W = 32;

    localparam logic [MAX_WIDTH-1:0] ONE_W = {{(MAX_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [MAX_CNT_W-1:0] ONE_C = {{(MAX_CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [MAX_WIDTH-1:0] bin2oh(input int unsigned idx,
                                                    input int unsigned width);
        logic [MAX_WIDTH-1:0] oh;
        oh = '0;
        if (idx < width) begin
            oh = ONE_W << idx;
        end
        return oh;
    endfunction

    function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] val,
                                                     input int unsigned cnt_w);
        logic [MAX_CNT_W-1:0] max_val;
        if (cnt_w >= MAX_CNT_W) begin
            max_val = '1;
        end else begin
            max_val = (ONE_C << cnt_w) - ONE_C;
        end
        return (val >= max_val) ? max_val : val + ONE_C;
    endfunction

endpackage

// File: rtl/bin2onehot.sv
// ---------------------------------------------------------------------------
// bin2onehot
//   Purely combinational binary-to-one-hot decoder. It is the structural
//   inverse of the priority encoder that feeds this interface.
//   Ports:
//     idx_i       in   IDX_BITS  binary index
//     oh_o        out  WIDTH     one-hot decode, zero when out of range
//     in_range_o  out  1         idx_i < WIDTH
// ---------------------------------------------------------------------------
module bin2onehot
    import pe_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned IDX_BITS = $clog2(WIDTH)
) (
    input  logic [IDX_BITS-1:0] idx_i,
    output logic [WIDTH-1:0]    oh_o,
    output logic                in_range_o
);

    assign oh_o       = WIDTH'(bin2oh(32'(idx_i), WIDTH));
    // In-range can only be false when WIDTH is not a power of two.
    assign in_range_o = (32'(idx_i) < WIDTH);

endmodule

// File: rtl/index_pending_decoder.sv
// ---------------------------------------------------------------------------
// index_pending_decoder
//   Receiving end of an index+valid interface. Each accepted index is
//   decoded to a one-hot event, and the event is ORed into a sticky pending
//   vector. The vector holds the bits until the consumer clears them with
//   clr_mask. An event whose bit is already pending (and is not being cleared
//   in the same cycle) is counted as a drop in a saturating counter.
//
//   Handshake: an event transfers on a rising clk edge when in_valid and
//   in_ready are both high. in_ready depends only on the pending register,
//   never on in_valid. While in_ready is low, the source keeps in_valid and
//   in_idx stable until the transfer happens.
//
//   Ports:
//     clk, rst_n    clock (rising edge), asynchronous active-low reset
//     in_valid/in_idx/in_ready   index event handshake
//     clr_mask      per-bit pending clear, sampled every clk
//     clr_cnt       synchronous drop counter clear
//     evt_valid     one-cycle pulse, the cycle after an accept
//     evt_onehot    decoded one-hot of the last accept (zero if out of range)
//     pending       sticky pending vector
//     pending_any   OR of pending
//     drop_cnt      saturating collision count (CNT_W <= 32)
//     err_range     sticky out-of-range index flag
// ---------------------------------------------------------------------------
module index_pending_decoder
    import pe_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned IDX_BITS = $clog2(WIDTH),
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [IDX_BITS-1:0] in_idx,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    clr_mask,
    input  logic                clr_cnt,
    output logic                evt_valid,
    output logic [WIDTH-1:0]    evt_onehot,
    output logic [WIDTH-1:0]    pending,
    output logic                pending_any,
    output logic [CNT_W-1:0]    drop_cnt,
    output logic                err_range
);

    logic [WIDTH-1:0] pending_q, pending_d;
    logic [WIDTH-1:0] evt_onehot_q, evt_onehot_d;
    logic             evt_valid_q, evt_valid_d;
    logic             err_range_q, err_range_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [WIDTH-1:0] dec_oh;
    logic             dec_in_range;
    logic             accept;
    logic             collision;

    bin2onehot #(
        .WIDTH    (WIDTH),
        .IDX_BITS (IDX_BITS)
    ) u_bin2onehot (
        .idx_i      (in_idx),
        .oh_o       (dec_oh),
        .in_range_o (dec_in_range)
    );

    // Full means every bit is set. Clearing a bit only changes pending_q at the
    // next edge, so in_ready rises one cycle after the clear.
    assign in_ready    = ~&pending_q;
    assign pending_any = |pending_q;
    assign accept      = in_valid & in_ready;

    // A bit that is cleared in the same cycle is not a collision, because the
    // new event simply re-arms it.
    assign collision = accept & dec_in_range & (|(pending_q & ~clr_mask & dec_oh));

    always_comb begin
        // Set wins over a same-cycle clear of the same bit.
        pending_d    = (pending_q & ~clr_mask) | (accept ? dec_oh : '0);
        evt_valid_d  = accept;
        evt_onehot_d = accept ? dec_oh : '0;
        err_range_d  = err_range_q | (accept & ~dec_in_range);
        if (clr_cnt) begin
            drop_cnt_d = '0;
        end else if (collision) begin
            drop_cnt_d = CNT_W'(sat_inc(MAX_CNT_W'(drop_cnt_q), CNT_W));
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q    <= '0;
            evt_onehot_q <= '0;
            evt_valid_q  <= 1'b0;
            err_range_q  <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            pending_q    <= pending_d;
            evt_onehot_q <= evt_onehot_d;
            evt_valid_q  <= evt_valid_d;
            err_range_q  <= err_range_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign pending    = pending_q;
    assign evt_valid  = evt_valid_q;
    assign evt_onehot = evt_onehot_q;
    assign err_range  = err_range_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_index_pending_decoder.sv
module tb_index_pending_decoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Instance A: WIDTH=8, CNT_W=8
    logic       a_valid, a_clrc, a_ready, a_ev, a_any, a_err;
    logic [2:0] a_idx;
    logic [7:0] a_clr, a_oh, a_pend, a_cnt;
    // Instance B: WIDTH=8, CNT_W=2
    logic       b_valid, b_clrc, b_ready, b_ev, b_any, b_err;
    logic [2:0] b_idx;
    logic [7:0] b_clr, b_oh, b_pend;
    logic [1:0] b_cnt;
    // Instance C: WIDTH=6, CNT_W=8
    logic       c_valid, c_clrc, c_ready, c_ev, c_any, c_err;
    logic [2:0] c_idx;
    logic [5:0] c_clr, c_oh, c_pend;
    logic [7:0] c_cnt;

    index_pending_decoder #(.WIDTH(8), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_idx(a_idx), .in_ready(a_ready),
        .clr_mask(a_clr), .clr_cnt(a_clrc), .evt_valid(a_ev), .evt_onehot(a_oh),
        .pending(a_pend), .pending_any(a_any), .drop_cnt(a_cnt), .err_range(a_err)
    );
    index_pending_decoder #(.WIDTH(8), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_idx(b_idx), .in_ready(b_ready),
        .clr_mask(b_clr), .clr_cnt(b_clrc), .evt_valid(b_ev), .evt_onehot(b_oh),
        .pending(b_pend), .pending_any(b_any), .drop_cnt(b_cnt), .err_range(b_err)
    );
    index_pending_decoder #(.WIDTH(6), .CNT_W(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_valid), .in_idx(c_idx), .in_ready(c_ready),
        .clr_mask(c_clr), .clr_cnt(c_clrc), .evt_valid(c_ev), .evt_onehot(c_oh),
        .pending(c_pend), .pending_any(c_any), .drop_cnt(c_cnt), .err_range(c_err)
    );

    // Reference model: pending is a set of line numbers held as bits, the
    // drop count is a plain integer clipped at its maximum.
    typedef struct {
        logic [7:0] pend;
        int         cnt;
        bit         err;
        bit         ev;
        logic [7:0] oh;
    } mstate_t;

    mstate_t ma, mc;

    function automatic mstate_t model_zero();
        mstate_t z;
        z.pend = 8'h00; z.cnt = 0; z.err = 1'b0; z.ev = 1'b0; z.oh = 8'h00;
        return z;
    endfunction

    function automatic bit model_ready(input logic [7:0] p, input int width);
        int n;
        n = 0;
        for (int i = 0; i < width; i++) if ((p & (8'(1) << i)) != 0) n++;
        return n < width;
    endfunction

    function automatic mstate_t model_next(input mstate_t s, input int width, input int cmax,
                                           input bit v, input int idx, input logic [7:0] clr,
                                           input bit clrc);
        mstate_t n;
        bit hit;
        logic [7:0] bitm;
        n = s;
        hit = 1'b0;
        for (int i = 0; i < width; i++) begin
            bitm = 8'(1) << i;
            if ((clr & bitm) != 0) n.pend = n.pend & ~bitm;
        end
        n.ev = v && model_ready(s.pend, width);
        n.oh = 8'h00;
        if (n.ev) begin
            if (idx >= 0 && idx < width) begin
                bitm = 8'(1) << idx;
                n.oh = bitm;
                hit = ((s.pend & bitm) != 0) && ((clr & bitm) == 0);
                n.pend = n.pend | bitm;
            end else begin
                n.err = 1'b1;
            end
        end
        if (clrc) n.cnt = 0;
        else if (hit && n.cnt < cmax) n.cnt = n.cnt + 1;
        return n;
    endfunction

    // Driver tasks: present inputs, advance the model, wait one edge, settle.
    task automatic step_a(input bit v, input int idx, input logic [7:0] clr, input bit clrc);
        a_valid = v; a_idx = 3'(idx); a_clr = clr; a_clrc = clrc;
        ma = model_next(ma, 8, 255, v, idx, clr, clrc);
        @(posedge clk); #1;
    endtask

    task automatic step_b(input bit v, input int idx, input logic [7:0] clr, input bit clrc);
        b_valid = v; b_idx = 3'(idx); b_clr = clr; b_clrc = clrc;
        @(posedge clk); #1;
    endtask

    task automatic step_c(input bit v, input int idx, input logic [7:0] clr, input bit clrc);
        c_valid = v; c_idx = 3'(idx); c_clr = clr[5:0]; c_clrc = clrc;
        mc = model_next(mc, 6, 255, v, idx, clr, clrc);
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        a_valid = 0; a_idx = 0; a_clr = 0; a_clrc = 0;
        b_valid = 0; b_idx = 0; b_clr = 0; b_clrc = 0;
        c_valid = 0; c_idx = 0; c_clr = 0; c_clrc = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        ma = model_zero(); mc = model_zero();
        @(posedge clk); #1;
        total++; if (a_pend !== 8'h00) begin bad++; $display("FAIL reset_pending got=%h exp=00", a_pend); end
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", a_ready); end
        total++; if (a_cnt !== 8'h00) begin bad++; $display("FAIL reset_drop_cnt got=%h exp=00", a_cnt); end
        total++; if (a_ev !== 1'b0) begin bad++; $display("FAIL reset_evt_valid got=%b exp=0", a_ev); end
        total++; if (a_oh !== 8'h00) begin bad++; $display("FAIL reset_evt_onehot got=%h exp=00", a_oh); end
        total++; if (a_any !== 1'b0) begin bad++; $display("FAIL reset_pending_any got=%b exp=0", a_any); end
        total++; if (a_err !== 1'b0 || c_err !== 1'b0) begin bad++; $display("FAIL reset_err_range got=%b/%b exp=0/0", a_err, c_err); end
    endtask

    task automatic test_single();
        step_a(1, 5, 8'h00, 0);
        total++; if (a_ev !== 1'b1) begin bad++; $display("FAIL single_evt_valid got=%b exp=1", a_ev); end
        total++; if (a_oh !== 8'h20) begin bad++; $display("FAIL single_evt_onehot got=%h exp=20", a_oh); end
        total++; if (a_pend !== 8'h20) begin bad++; $display("FAIL single_pending got=%h exp=20", a_pend); end
        total++; if (a_any !== 1'b1) begin bad++; $display("FAIL single_pending_any got=%b exp=1", a_any); end
        step_a(0, 0, 8'h00, 0);
        total++; if (a_ev !== 1'b0 || a_oh !== 8'h00) begin bad++; $display("FAIL single_pulse_end got=%b/%h exp=0/00", a_ev, a_oh); end
        total++; if (a_pend !== 8'h20) begin bad++; $display("FAIL single_sticky got=%h exp=20", a_pend); end
    endtask

    task automatic test_collision();
        step_a(1, 5, 8'h00, 0);
        total++; if (a_cnt !== 8'd1) begin bad++; $display("FAIL coll_drop_cnt got=%0d exp=1", a_cnt); end
        total++; if (a_pend !== 8'h20 || a_ev !== 1'b1) begin bad++; $display("FAIL coll_pending got=%h/%b exp=20/1", a_pend, a_ev); end
        step_a(1, 5, 8'h20, 0);
        total++; if (a_cnt !== 8'd1) begin bad++; $display("FAIL coll_clr_same_cnt got=%0d exp=1", a_cnt); end
        total++; if (a_pend !== 8'h20) begin bad++; $display("FAIL coll_set_wins got=%h exp=20", a_pend); end
        step_a(0, 0, 8'h00, 0);
    endtask

    task automatic test_full();
        step_a(0, 0, 8'hFF, 0);
        total++; if (a_pend !== 8'h00) begin bad++; $display("FAIL full_clear got=%h exp=00", a_pend); end
        for (int i = 0; i < 8; i++) step_a(1, i, 8'h00, 0);
        total++; if (a_pend !== 8'hFF) begin bad++; $display("FAIL full_pending got=%h exp=ff", a_pend); end
        total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", a_ready); end
        total++; if (a_cnt !== 8'd1) begin bad++; $display("FAIL full_fill_cnt got=%0d exp=1", a_cnt); end
        for (int k = 0; k < 2; k++) begin
            step_a(1, 3, 8'h00, 0);
            total++; if (a_ev !== 1'b0 || a_pend !== 8'hFF || a_cnt !== 8'd1) begin
                bad++; $display("FAIL full_blocked ev=%b pend=%h cnt=%0d exp=0/ff/1", a_ev, a_pend, a_cnt);
            end
        end
        a_clr = 8'h01;
        #1;
        total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL full_ready_same_cycle got=%b exp=0", a_ready); end
        step_a(1, 3, 8'h01, 0);
        total++; if (a_ready !== 1'b1 || a_pend !== 8'hFE || a_ev !== 1'b0) begin
            bad++; $display("FAIL full_after_clr ready=%b pend=%h ev=%b exp=1/fe/0", a_ready, a_pend, a_ev);
        end
        step_a(1, 3, 8'h00, 0);
        total++; if (a_ev !== 1'b1 || a_oh !== 8'h08) begin bad++; $display("FAIL full_held_accept got=%b/%h exp=1/08", a_ev, a_oh); end
        total++; if (a_cnt !== 8'd2) begin bad++; $display("FAIL full_held_cnt got=%0d exp=2", a_cnt); end
        total++; if (a_pend !== 8'hFE) begin bad++; $display("FAIL full_held_pending got=%h exp=fe", a_pend); end
        step_a(0, 0, 8'h00, 0);
    endtask

    task automatic test_saturate();
        int exp_cnt;
        step_b(1, 2, 8'h00, 0);
        total++; if (b_pend !== 8'h04 || b_cnt !== 2'd0) begin bad++; $display("FAIL sat_first got=%h/%0d exp=04/0", b_pend, b_cnt); end
        for (int k = 1; k <= 4; k++) begin
            step_b(1, 2, 8'h00, 0);
            exp_cnt = (k < 3) ? k : 3;
            total++; if (b_cnt !== 2'(exp_cnt)) begin bad++; $display("FAIL sat_count k=%0d got=%0d exp=%0d", k, b_cnt, exp_cnt); end
        end
        step_b(1, 2, 8'h00, 1);
        total++; if (b_cnt !== 2'd0) begin bad++; $display("FAIL sat_clr_priority got=%0d exp=0", b_cnt); end
        total++; if (b_pend !== 8'h04) begin bad++; $display("FAIL sat_pending got=%h exp=04", b_pend); end
        step_b(0, 0, 8'h00, 0);
    endtask

    task automatic test_range();
        step_c(1, 1, 8'h00, 0);
        total++; if (c_pend !== 6'h02 || c_err !== 1'b0) begin bad++; $display("FAIL range_setup got=%h/%b exp=02/0", c_pend, c_err); end
        step_c(1, 7, 8'h00, 0);
        total++; if (c_err !== 1'b1) begin bad++; $display("FAIL range_err got=%b exp=1", c_err); end
        total++; if (c_ev !== 1'b1 || c_oh !== 6'h00) begin bad++; $display("FAIL range_event got=%b/%h exp=1/00", c_ev, c_oh); end
        total++; if (c_pend !== 6'h02) begin bad++; $display("FAIL range_pending got=%h exp=02", c_pend); end
        step_c(1, 6, 8'h00, 0);
        total++; if (c_oh !== 6'h00 || c_pend !== 6'h02) begin bad++; $display("FAIL range_idx6 got=%h/%h exp=00/02", c_oh, c_pend); end
        step_c(0, 0, 8'hFF, 0);
        total++; if (c_err !== 1'b1 || c_ev !== 1'b0) begin bad++; $display("FAIL range_sticky got=%b/%b exp=1/0", c_err, c_ev); end
    endtask

    task automatic test_random();
        logic [7:0] clr;
        for (int n = 0; n < 600; n++) begin
            clr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            if (n < 300) begin
                step_a($urandom_range(0, 3) != 0, $urandom_range(0, 7), clr, $urandom_range(0, 15) == 0);
                total++; if (a_ready !== model_ready(ma.pend, 8) || a_pend !== ma.pend || a_any !== (ma.pend != 0)) begin
                    bad++; $display("FAIL rand_a_pending n=%0d got=%h/%b exp=%h", n, a_pend, a_ready, ma.pend);
                end
                total++; if (a_ev !== ma.ev || a_oh !== ma.oh) begin
                    bad++; $display("FAIL rand_a_event n=%0d got=%b/%h exp=%b/%h", n, a_ev, a_oh, ma.ev, ma.oh);
                end
                total++; if (a_cnt !== 8'(ma.cnt) || a_err !== ma.err) begin
                    bad++; $display("FAIL rand_a_cnt n=%0d got=%0d/%b exp=%0d/%b", n, a_cnt, a_err, ma.cnt, ma.err);
                end
            end else begin
                step_c($urandom_range(0, 3) != 0, $urandom_range(0, 7), clr, $urandom_range(0, 15) == 0);
                total++; if (c_ready !== model_ready(mc.pend, 6) || c_pend !== mc.pend[5:0] || c_any !== (mc.pend != 0)) begin
                    bad++; $display("FAIL rand_c_pending n=%0d got=%h/%b exp=%h", n, c_pend, c_ready, mc.pend);
                end
                total++; if (c_ev !== mc.ev || c_oh !== mc.oh[5:0]) begin
                    bad++; $display("FAIL rand_c_event n=%0d got=%b/%h exp=%b/%h", n, c_ev, c_oh, mc.ev, mc.oh);
                end
                total++; if (c_cnt !== 8'(mc.cnt) || c_err !== mc.err) begin
                    bad++; $display("FAIL rand_c_cnt n=%0d got=%0d/%b exp=%0d/%b", n, c_cnt, c_err, mc.cnt, mc.err);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        step_a(0, 0, 8'hFF, 0);
        step_a(1, 4, 8'h00, 0);
        step_a(1, 4, 8'h00, 0);
        #2 rst_n = 1'b0;
        #1;
        total++; if (a_pend !== 8'h00 || a_any !== 1'b0 || a_ready !== 1'b1) begin
            bad++; $display("FAIL midrst_pending got=%h/%b/%b exp=00/0/1", a_pend, a_any, a_ready);
        end
        total++; if (a_ev !== 1'b0 || a_oh !== 8'h00 || a_cnt !== 8'h00) begin
            bad++; $display("FAIL midrst_event got=%b/%h/%0d exp=0/00/0", a_ev, a_oh, a_cnt);
        end
        total++; if (c_err !== 1'b0 || c_pend !== 6'h00) begin bad++; $display("FAIL midrst_c got=%b/%h exp=0/00", c_err, c_pend); end
        idle_inputs();
        ma = model_zero(); mc = model_zero();
        @(posedge clk);
        #3 rst_n = 1'b1;
        step_a(0, 0, 8'h00, 0);
        total++; if (a_pend !== 8'h00 || a_ev !== 1'b0) begin bad++; $display("FAIL midrst_no_survivor got=%h/%b exp=00/0", a_pend, a_ev); end
    endtask

    initial begin
        idle_inputs();
        ma = model_zero();
        mc = model_zero();
        test_reset();
        test_single();
        test_collision();
        test_full();
        test_saturate();
        test_range();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
